// File: rtl/systolic_sequencer_pkg.sv
// Shared definitions for the systolic sequencer: defaults, state encoding, clog2 helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_sequencer_pkg;

  localparam int N_DEF    = 8;
  localparam int W_DEF    = 16;
  localparam int PACE_DEF = 30;
  localparam int LAT_DEF  = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  // Ceiling log2, floored at 1 so a width derived from it is never zero.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/systolic_sequencer_if.sv
// Sample-source and result channels of the sequencer, bundled with host/sequencer views.
// Latency: n/a (wiring only).
// Backpressure: source is paced by in_ready; results are fire-and-forget pulses.
interface systolic_sequencer_if #(
  parameter int W  = 16,
  parameter int IW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_index;

  // Host side: supplies samples, observes results.
  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data, out_index
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data, out_index
  );
endinterface

// File: rtl/systolic_sequencer_pace_timer.sv
// Pace counter for the sequencer: counts 0..PACE-1 and flags the slot tick (count 0).
// Latency: tick is combinational from the count register.
// Backpressure: none; clear wins over enable.
module seq_pace_timer
  import systolic_sequencer_pkg::*;
#(
  parameter int PACE = PACE_DEF
) (
  input  logic clk30x,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick,
  output logic last
);

  localparam int CW = clog2(PACE);

  logic [CW-1:0] cnt;

  // Free-running modulo-PACE count while enabled, parked at 0 when cleared.
  always_ff @(posedge clk30x or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == CW'(PACE - 1)) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == '0);
  assign last = enable && (cnt == CW'(PACE - 1));

endmodule

// File: rtl/systolic_sequencer.sv
// Feeds one sample per PACE-cycle slot into a systolic array and re-indexes its results.
// Latency: result for input slot k pulses one cycle after the tick of slot k+LAT.
// Backpressure: none; a missing sample on a tick is replaced by 0 and flagged as underrun.
module systolic_sequencer
  import systolic_sequencer_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int W    = W_DEF,
  parameter int PACE = PACE_DEF,
  parameter int LAT  = LAT_DEF
) (
  input  logic                  clk30x,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            num_frames,
  systolic_sequencer_if.slave   bus,
  output logic [W-1:0]          arr_xin,
  output logic                  arr_rst,
  input  logic [W-1:0]          arr_yout,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun_err
);

  localparam int IW      = clog2(N);
  localparam int SW_NEED = clog2(256 * N + LAT + 1);
  localparam int SW      = (SW_NEED > 11) ? SW_NEED : 11;

  state_t        state, next_state;
  logic [1:0]    rst_sync;
  logic          rst_core_n;
  logic [SW-1:0] slot, total, run_last, drain_last;
  logic [IW-1:0] oidx;
  logic [7:0]    nf_eff;
  logic          tick, last, run_tick, drain_tick, emit;

  // Reset asserts immediately, releases two clk30x edges later.
  always_ff @(posedge clk30x or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_core_n = rst_sync[1];

  seq_pace_timer #(.PACE(PACE)) u_pace (
    .clk30x (clk30x),
    .rst_n  (rst_core_n),
    .clear  ((state == S_IDLE) || (state == S_FIN)),
    .enable (busy),
    .tick   (tick),
    .last   (last)
  );

  assign run_tick   = (state == S_RUN) && tick;
  assign drain_tick = (state == S_DRAIN) && tick;
  assign emit       = (run_tick || drain_tick) && (slot >= SW'(LAT));
  assign run_last   = total - 1'b1;
  assign drain_last = total + SW'(LAT) - 1'b1;
  assign nf_eff     = (num_frames == 8'd0) ? 8'd1 : num_frames;

  // State register.
  always_ff @(posedge clk30x or negedge rst_core_n) begin
    if (!rst_core_n) state <= S_IDLE;
    else             state <= next_state;
  end

  // Next-state: FLUSH spans one pace period, RUN/DRAIN end on their last slot tick.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_FLUSH;
      S_FLUSH: if (last) next_state = S_RUN;
      S_RUN:   if (tick && (slot == run_last)) next_state = (LAT == 0) ? S_FIN : S_DRAIN;
      S_DRAIN: if (tick && (slot == drain_last)) next_state = S_FIN;
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    arr_rst      = (state == S_IDLE) || (state == S_FLUSH);
    busy         = (state == S_FLUSH) || (state == S_RUN) || (state == S_DRAIN);
    done         = (state == S_FIN);
    bus.in_ready = run_tick;
  end

  // Run bookkeeping: frame length latched on start, slot and output index advance on ticks.
  always_ff @(posedge clk30x or negedge rst_core_n) begin
    if (!rst_core_n) begin
      total        <= '0;
      slot         <= '0;
      oidx         <= '0;
      underrun_err <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      total        <= SW'(nf_eff) * SW'(N);
      slot         <= '0;
      oidx         <= '0;
      underrun_err <= 1'b0;
    end else begin
      if (run_tick || drain_tick) slot <= slot + 1'b1;
      if (run_tick && !bus.in_valid) underrun_err <= 1'b1;
      if (emit) oidx <= (oidx == IW'(N - 1)) ? '0 : oidx + 1'b1;
    end
  end

  // Datapath: capture yout on the tick edge, hold a sample for its whole RUN slot.
  always_ff @(posedge clk30x or negedge rst_core_n) begin
    if (!rst_core_n) begin
      arr_xin       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_index <= '0;
    end else begin
      bus.out_valid <= emit;
      if (emit) begin
        bus.out_data  <= arr_yout;
        bus.out_index <= oidx;
      end
      if (run_tick) begin
        arr_xin <= bus.in_valid ? bus.in_data : '0;
      end else if (drain_tick || !((state == S_RUN) || (state == S_DRAIN))) begin
        arr_xin <= '0;
      end
    end
  end

endmodule
